// File: rtl/rv32i_exit_monitor_pkg.sv
// Shared definitions for the rv32i exit monitor: status codes, halt-source bits, ABI registers.
// Pure declarations, no timing.
// Used by the monitor top and the bench.
package rv32i_exit_monitor_pkg;

  typedef enum logic [2:0] {
    EXIT_RUN     = 3'd0,
    EXIT_PASS    = 3'd1,
    EXIT_FAIL    = 3'd2,
    EXIT_UNKNOWN = 3'd3,
    EXIT_TIMEOUT = 3'd4
  } exit_status_e;

  // Bit positions inside HALT_MASK
  localparam int HALT_ECALL    = 0;
  localparam int HALT_EBREAK   = 1;
  localparam int HALT_ILLEGAL  = 2;
  localparam int HALT_PC_LIMIT = 3;

  // ABI registers used by the riscv-tests exit convention
  localparam logic [4:0] REG_A0 = 5'd10;
  localparam logic [4:0] REG_A7 = 5'd17;

  // a7 selects whether the exit is recognised, a0 carries the verdict
  function automatic exit_status_e exit_decide(input logic [31:0] a0,
                                               input logic [31:0] a7,
                                               input logic [31:0] magic);
    if (a7 != magic) return EXIT_UNKNOWN;
    return (a0 == 32'd0) ? EXIT_PASS : EXIT_FAIL;
  endfunction

endpackage

// File: rtl/rv32i_exit_monitor_if.sv
// Bundle of core-side strobes, trace port and monitor results.
// Wires only; no latency.
// Trace port uses valid/ready; all other signals are plain strobes.
interface rv32i_exit_monitor_if #(parameter int CNT_WIDTH = 32);
  logic                 i_wb_ce;
  logic [31:0]          i_wb_pc;
  logic                 i_rd_wr;
  logic [4:0]           i_rd_addr;
  logic [31:0]          i_rd_data;
  logic                 i_exc_ecall;
  logic                 i_exc_ebreak;
  logic                 i_exc_illegal;
  logic                 o_halt;
  logic [2:0]           o_status;
  logic [31:0]          o_exit_code;
  logic [CNT_WIDTH-1:0] o_cycles;
  logic [CNT_WIDTH-1:0] o_instret;
  logic [31:0]          o_trace_pc;
  logic                 o_trace_valid;
  logic                 i_trace_ready;
  logic                 o_trace_ovf;

  modport master (
    output i_wb_ce, i_wb_pc, i_rd_wr, i_rd_addr, i_rd_data,
           i_exc_ecall, i_exc_ebreak, i_exc_illegal, i_trace_ready,
    input  o_halt, o_status, o_exit_code, o_cycles, o_instret,
           o_trace_pc, o_trace_valid, o_trace_ovf
  );

  modport slave (
    input  i_wb_ce, i_wb_pc, i_rd_wr, i_rd_addr, i_rd_data,
           i_exc_ecall, i_exc_ebreak, i_exc_illegal, i_trace_ready,
    output o_halt, o_status, o_exit_code, o_cycles, o_instret,
           o_trace_pc, o_trace_valid, o_trace_ovf
  );
endinterface

// File: rtl/rv32i_trace_fifo.sv
// Synchronous FIFO with drop-on-full, no fall-through.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: a push into a full FIFO without a same-cycle pop is dropped and flagged.
module rv32i_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB distinguishes full from empty when the indices coincide
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rv32i_exit_monitor.sv
// Run-control monitor: shadows a0/a7, counts cycles/instret, decides exit status, traces retired PCs.
// Latency: o_halt/o_status change one cycle after the halting retire or watchdog expiry.
// Backpressure: trace FIFO drops new PCs when full (sticky o_trace_ovf); retires are never stalled.
module rv32i_exit_monitor
  import rv32i_exit_monitor_pkg::*;
#(
  parameter int          CNT_WIDTH      = 32,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter logic [3:0]  HALT_MASK      = 4'b0011,
  parameter logic [31:0] PC_LIMIT       = 32'h0001_3FFC,
  parameter int          TRACE_DEPTH    = 16,
  parameter logic [31:0] EXIT_MAGIC     = 32'h5D
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  rv32i_exit_monitor_if.slave   mon
);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  exit_status_e         state;
  exit_status_e         state_nxt;
  logic [31:0]          shadow_a0;
  logic [31:0]          shadow_a7;
  logic [31:0]          a0_nxt;
  logic [31:0]          a7_nxt;
  logic [31:0]          exit_code;
  logic [CNT_WIDTH-1:0] cycles;
  logic [CNT_WIDTH-1:0] instret;
  logic                 running;
  logic                 retire;
  logic                 halt_src;
  logic                 halt_evt;
  logic                 timeout_evt;
  logic                 ovf;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_drop;

  assign running = (state == EXIT_RUN);
  assign retire  = running && mon.i_wb_ce;

  // Shadows as seen by a halt on this edge, including a same-cycle rd write
  assign a0_nxt = (retire && mon.i_rd_wr && mon.i_rd_addr == REG_A0) ? mon.i_rd_data : shadow_a0;
  assign a7_nxt = (retire && mon.i_rd_wr && mon.i_rd_addr == REG_A7) ? mon.i_rd_data : shadow_a7;

  assign halt_src = (HALT_MASK[HALT_ECALL]    && mon.i_exc_ecall)
                 || (HALT_MASK[HALT_EBREAK]   && mon.i_exc_ebreak)
                 || (HALT_MASK[HALT_ILLEGAL]  && mon.i_exc_illegal)
                 || (HALT_MASK[HALT_PC_LIMIT] && (mon.i_wb_pc >= PC_LIMIT));
  assign halt_evt    = retire && halt_src;
  assign timeout_evt = running && (TIMEOUT_CYCLES != 0) && (cycles == TO_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= EXIT_RUN;
    else          state <= state_nxt;
  end

  // Next state: a halting retire takes priority over watchdog expiry
  always_comb begin
    state_nxt = state;
    if (state == EXIT_RUN) begin
      if (halt_evt)         state_nxt = exit_decide(a0_nxt, a7_nxt, EXIT_MAGIC);
      else if (timeout_evt) state_nxt = EXIT_TIMEOUT;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    mon.o_halt   = (state != EXIT_RUN);
    mon.o_status = state;
  end

  // Shadow a0/a7 and exit code capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_a0 <= '0;
      shadow_a7 <= '0;
      exit_code <= '0;
    end else begin
      shadow_a0 <= a0_nxt;
      shadow_a7 <= a7_nxt;
      if (halt_evt) exit_code <= {1'b0, a0_nxt[31:1]};
    end
  end

  // Saturating cycle/instret counters, frozen once halted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycles  <= '0;
      instret <= '0;
    end else if (running) begin
      if (cycles != '1)            cycles  <= cycles + CNT_WIDTH'(1);
      if (retire && instret != '1) instret <= instret + CNT_WIDTH'(1);
    end
  end

  // Sticky overflow flag for dropped trace entries
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       ovf <= 1'b0;
    else if (fifo_drop) ovf <= 1'b1;
  end

  rv32i_trace_fifo #(
    .WIDTH (32),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (retire),
    .din   (mon.i_wb_pc),
    .pop   (mon.i_trace_ready),
    .dout  (mon.o_trace_pc),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign mon.o_trace_valid = !fifo_empty;
  assign mon.o_trace_ovf   = ovf;
  assign mon.o_exit_code   = exit_code;
  assign mon.o_cycles      = cycles;
  assign mon.o_instret     = instret;
endmodule

// File: tb/tb_rv32i_exit_monitor.sv
// Directed bench for rv32i_exit_monitor: two instances with different halt/watchdog settings.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Trace ready is driven explicitly per step.
module tb_rv32i_exit_monitor;
  import rv32i_exit_monitor_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;

  rv32i_exit_monitor_if #(.CNT_WIDTH(32)) ifa ();
  rv32i_exit_monitor_if #(.CNT_WIDTH(8))  ifb ();

  rv32i_exit_monitor #(
    .CNT_WIDTH(32), .TIMEOUT_CYCLES(50), .HALT_MASK(4'b0011),
    .PC_LIMIT(32'h0001_3FFC), .TRACE_DEPTH(16), .EXIT_MAGIC(32'h5D)
  ) dut_a (.i_clk(clk), .i_rst_n(rst_a), .mon(ifa));

  rv32i_exit_monitor #(
    .CNT_WIDTH(8), .TIMEOUT_CYCLES(0), .HALT_MASK(4'b1100),
    .PC_LIMIT(32'h0001_3FFC), .TRACE_DEPTH(16), .EXIT_MAGIC(32'h5D)
  ) dut_b (.i_clk(clk), .i_rst_n(rst_b), .mon(ifb));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifa.i_wb_ce = 0; ifa.i_wb_pc = 0; ifa.i_rd_wr = 0; ifa.i_rd_addr = 0; ifa.i_rd_data = 0;
    ifa.i_exc_ecall = 0; ifa.i_exc_ebreak = 0; ifa.i_exc_illegal = 0;
    ifb.i_wb_ce = 0; ifb.i_wb_pc = 0; ifb.i_rd_wr = 0; ifb.i_rd_addr = 0; ifb.i_rd_data = 0;
    ifb.i_exc_ecall = 0; ifb.i_exc_ebreak = 0; ifb.i_exc_illegal = 0;
  endtask

  // exc = {illegal, ebreak, ecall}; one retire for one clock, then inputs return idle
  task automatic retire(input bit sel, input logic [31:0] pc, input logic wr,
                        input logic [4:0] addr, input logic [31:0] data, input logic [2:0] exc);
    if (!sel) begin
      ifa.i_wb_ce = 1; ifa.i_wb_pc = pc; ifa.i_rd_wr = wr; ifa.i_rd_addr = addr;
      ifa.i_rd_data = data; ifa.i_exc_ecall = exc[0]; ifa.i_exc_ebreak = exc[1];
      ifa.i_exc_illegal = exc[2];
    end else begin
      ifb.i_wb_ce = 1; ifb.i_wb_pc = pc; ifb.i_rd_wr = wr; ifb.i_rd_addr = addr;
      ifb.i_rd_data = data; ifb.i_exc_ecall = exc[0]; ifb.i_exc_ebreak = exc[1];
      ifb.i_exc_illegal = exc[2];
    end
    tick();
    clear_inputs();
  endtask

  task automatic reset_a();
    rst_a = 0; #2; rst_a = 1; #1;
  endtask

  task automatic reset_b();
    rst_b = 0; #2; rst_b = 1; #1;
  endtask

  initial begin
    rst_a = 0; rst_b = 0;
    clear_inputs();
    ifa.i_trace_ready = 0; ifb.i_trace_ready = 0;
    tick();
    // Reset state
    chk("rst_halt",   ifa.o_halt, 0);
    chk("rst_status", ifa.o_status, EXIT_RUN);
    chk("rst_cycles", ifa.o_cycles, 0);
    chk("rst_instr",  ifa.o_instret, 0);
    chk("rst_exit",   ifa.o_exit_code, 0);
    chk("rst_valid",  ifa.o_trace_valid, 0);
    chk("rst_pc",     ifa.o_trace_pc, 0);
    chk("rst_ovf",    ifa.o_trace_ovf, 0);
    rst_a = 1; rst_b = 1;

    // PASS: a7=0x5d, a0=0, then ECALL
    retire(0, 32'h100, 1, REG_A7, 32'h5D, 3'b000);
    retire(0, 32'h104, 1, REG_A0, 32'h0, 3'b000);
    chk("pass_pre_halt", ifa.o_halt, 0);
    retire(0, 32'h108, 0, 5'd0, 32'h0, 3'b001);
    chk("pass_halt",   ifa.o_halt, 1);
    chk("pass_status", ifa.o_status, EXIT_PASS);
    chk("pass_exit",   ifa.o_exit_code, 0);
    chk("pass_instr",  ifa.o_instret, 3);
    chk("pass_cycles", ifa.o_cycles, 3);
    retire(0, 32'h10C, 1, REG_A0, 32'h8, 3'b000);
    tick();
    chk("halted_cycles", ifa.o_cycles, 3);
    chk("halted_instr",  ifa.o_instret, 3);
    chk("halted_status", ifa.o_status, EXIT_PASS);
    ifa.i_trace_ready = 1;
    chk("drain0", ifa.o_trace_pc, 32'h100);
    tick();
    chk("drain1", ifa.o_trace_pc, 32'h104);
    tick();
    chk("drain2", ifa.o_trace_pc, 32'h108);
    chk("drain2_vld", ifa.o_trace_valid, 1);
    tick();
    chk("drain_empty", ifa.o_trace_valid, 0);
    ifa.i_trace_ready = 0;

    // FAIL: a0=6 written by the EBREAK retire itself
    reset_a();
    retire(0, 32'h200, 1, REG_A7, 32'h5D, 3'b000);
    retire(0, 32'h204, 1, REG_A0, 32'h6, 3'b010);
    chk("fail_status", ifa.o_status, EXIT_FAIL);
    chk("fail_exit",   ifa.o_exit_code, 32'h3);
    chk("fail_instr",  ifa.o_instret, 2);

    // Illegal is not a halt source for mask 0011
    reset_a();
    retire(0, 32'h300, 0, 5'd0, 32'h0, 3'b100);
    chk("illegal_nohalt", ifa.o_halt, 0);
    chk("illegal_instr",  ifa.o_instret, 1);

    // Watchdog expiry at 50 cycles
    reset_a();
    repeat (49) tick();
    chk("wd_cycles49", ifa.o_cycles, 49);
    chk("wd_pre",      ifa.o_halt, 0);
    tick();
    chk("wd_status", ifa.o_status, EXIT_TIMEOUT);
    chk("wd_cycles", ifa.o_cycles, 50);
    tick();
    chk("wd_frozen", ifa.o_cycles, 50);

    // Halt on the same edge as the watchdog wins (a7 unset -> UNKNOWN)
    reset_a();
    repeat (49) tick();
    retire(0, 32'h400, 0, 5'd0, 32'h0, 3'b001);
    chk("race_status", ifa.o_status, EXIT_UNKNOWN);
    chk("race_cycles", ifa.o_cycles, 50);
    chk("race_instr",  ifa.o_instret, 1);

    // Trace overflow: 20 pushes into 16 entries, then drain in order
    reset_a();
    for (int i = 0; i < 20; i++) begin
      retire(0, 32'h1000 + 32'(4 * i), 0, 5'd0, 32'h0, 3'b000);
      if (i == 15) chk("ovf_at16", ifa.o_trace_ovf, 0);
      if (i == 16) chk("ovf_at17", ifa.o_trace_ovf, 1);
    end
    chk("ovf_instr", ifa.o_instret, 20);
    ifa.i_trace_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d", i), ifa.o_trace_pc, 32'h1000 + 32'(4 * i));
      tick();
    end
    chk("ovf_empty",  ifa.o_trace_valid, 0);
    chk("ovf_sticky", ifa.o_trace_ovf, 1);
    ifa.i_trace_ready = 0;

    // Asynchronous reset mid-run with counters at 0x1F
    reset_a();
    for (int i = 0; i < 31; i++) retire(0, 32'h2000 + 32'(4 * i), 0, 5'd0, 32'h0, 3'b000);
    chk("mid_cycles", ifa.o_cycles, 32'h1F);
    chk("mid_instr",  ifa.o_instret, 32'h1F);
    #2 rst_a = 0;
    #1;
    chk("async_cycles", ifa.o_cycles, 0);
    chk("async_instr",  ifa.o_instret, 0);
    chk("async_valid",  ifa.o_trace_valid, 0);
    chk("async_ovf",    ifa.o_trace_ovf, 0);
    #1 rst_a = 1;
    tick();
    chk("restart_cycles", ifa.o_cycles, 1);
    chk("restart_status", ifa.o_status, EXIT_RUN);

    // Instance B: illegal halts, a7 unset -> UNKNOWN
    reset_b();
    retire(1, 32'h500, 0, 5'd0, 32'h0, 3'b001);
    chk("b_ecall_nohalt", ifb.o_halt, 0);
    retire(1, 32'h504, 0, 5'd0, 32'h0, 3'b100);
    chk("b_illegal", ifb.o_status, EXIT_UNKNOWN);

    // Instance B: PC limit boundary
    reset_b();
    retire(1, 32'h0001_3FF8, 1, REG_A7, 32'h5D, 3'b000);
    chk("b_below_limit", ifb.o_halt, 0);
    retire(1, 32'h0001_3FFC, 0, 5'd0, 32'h0, 3'b000);
    chk("b_at_limit", ifb.o_status, EXIT_PASS);
    chk("b_instr",    ifb.o_instret, 2);

    // Instance B: 8-bit counter saturates, watchdog disabled
    reset_b();
    repeat (300) tick();
    chk("b_sat_cycles", ifb.o_cycles, 8'hFF);
    chk("b_no_timeout", ifb.o_status, EXIT_RUN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32i_exit_monitor.md
Name: rv32i_exit_monitor

Overview:
Synthesizable run-control and exit-detection block for rv32i_soc bring-up, on both simulation and FPGA.
- Watches the core's writeback and exception strobes.
- Shadows a0/a7, counts cycles and retired instructions, and enforces a cycle-limit watchdog.
- Decides PASS/FAIL/UNKNOWN/TIMEOUT using the riscv-tests exit convention (a7 == 0x5d, a0 == 0 means pass).
- Buffers retired PCs in a trace FIFO that a debug port or bench drains.
- Sits beside the core inside the SoC and generalises the halt policy into a runtime-independent, parametrised block.

Parameters:
CNT_WIDTH, 32, width of the cycle and instret counters (8..64)
TIMEOUT_CYCLES, 10000, watchdog limit in cycles; 0 disables the watchdog
HALT_MASK, 4'b0011, halt sources: bit0 ECALL, bit1 EBREAK, bit2 ILLEGAL, bit3 PC_LIMIT
PC_LIMIT, 32'h0001_3FFC, retire PC at or above this halts when HALT_MASK[3] is set
TRACE_DEPTH, 16, trace FIFO entries; power of two, >= 2
EXIT_MAGIC, 32'h5D, required a7 value for a valid exit

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_wb_ce  in  1  one instruction retires this cycle
i_wb_pc  in  32  PC of the retiring instruction
i_rd_wr  in  1  retiring instruction writes rd
i_rd_addr  in  5  destination register
i_rd_data  in  32  value written to rd
i_exc_ecall  in  1  retiring instruction is ECALL (qualified by i_wb_ce)
i_exc_ebreak  in  1  retiring instruction is EBREAK (qualified by i_wb_ce)
i_exc_illegal  in  1  retiring instruction is illegal (qualified by i_wb_ce)
o_halt  out  1  core must stop; level signal
o_status  out  3  0 RUN, 1 PASS, 2 FAIL, 3 UNKNOWN, 4 TIMEOUT
o_exit_code  out  32  shadow a0 >> 1, captured at halt
o_cycles  out  CNT_WIDTH  cycles spent in RUN
o_instret  out  CNT_WIDTH  instructions retired in RUN
o_trace_pc  out  32  FIFO head
o_trace_valid  out  1  FIFO not empty
i_trace_ready  in  1  consumer pops the head when valid && ready
o_trace_ovf  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
Reset (asynchronous, any time, including mid-run):
- state RUN, all outputs 0, shadows 0, FIFO empty, o_trace_ovf 0.

Shadow registers:
- On i_wb_ce && i_rd_wr && i_rd_addr != 0: rd 10 updates shadow_a0; rd 17 updates shadow_a7.
- x0 writes are ignored.

Counters (only while in RUN):
- o_cycles increments every clock.
- o_instret increments on i_wb_ce.
- Both saturate at all-ones (no wrap).
- Both freeze on leaving RUN.

Halt event (RUN only):
- Condition is i_wb_ce && (HALT_MASK[0]&ecall | HALT_MASK[1]&ebreak | HALT_MASK[2]&illegal | HALT_MASK[3]&(i_wb_pc >= PC_LIMIT)).
- The decision uses shadow values that already include a same-cycle rd write.
- Next state: PASS if a7 == EXIT_MAGIC and a0 == 0; FAIL if a7 == EXIT_MAGIC and a0 != 0; UNKNOWN otherwise.
- o_exit_code is captured on the same edge.
- The halting instruction is counted in instret and pushed to the trace FIFO.

Watchdog (RUN only):
- If TIMEOUT_CYCLES != 0 and o_cycles == TIMEOUT_CYCLES-1 at a clock edge, the next state is TIMEOUT.
- If a halt event and the timeout fall on the same edge, the halt event wins.

Terminal states:
- PASS, FAIL, UNKNOWN and TIMEOUT are sticky until reset.
- o_halt = (state != RUN), registered: it rises exactly one cycle after the event cycle.
- Retirements while halted are ignored (no counts, no pushes, no shadow updates).

Trace FIFO:
- Push on each qualified retire in RUN.
- Pop on o_trace_valid && i_trace_ready; popping continues while halted so the FIFO can drain.
- Full with push and no pop: the new entry is dropped and o_trace_ovf is set.
- Full with push and pop: both happen; count unchanged.
- Empty with push and ready: push only; valid rises the next cycle (no fall-through).
- Pointer width is log2(TRACE_DEPTH) plus one wrap bit.

Decomposition:
- as_rv32i_header.vh gains:
  - status encodings: EXIT_RUN, EXIT_PASS, EXIT_FAIL, EXIT_UNKNOWN, EXIT_TIMEOUT;
  - HALT_MASK bit indices;
  - a0/a7 register indices.
- One sub-module, rv32i_trace_fifo: a synchronous FIFO parametrised in width and depth, with push/pop, full/empty and drop-on-full.
- The monitor FSM, shadows and counters stay in the top level.

Test Plan:
- Write a7 = 0x5d, a0 = 0, then ECALL retires at cycle N -> o_halt = 1 at N+1, o_status = 1, o_exit_code = 0, instret counts the ECALL.
- a7 = 0x5d, a0 = 0x6 written in the same retire as EBREAK -> o_status = 2 (FAIL), o_exit_code = 0x3.
- TIMEOUT_CYCLES = 50, no halt source -> o_status = 4 with o_cycles = 50; halt event at cycle 49 instead -> halt wins, not timeout.
- 20 retires, TRACE_DEPTH = 16, i_trace_ready = 0 -> 16 entries kept, o_trace_ovf = 1; draining yields the first 16 PCs in order.
- Reset pulsed mid-run with counters at 0x1F -> all outputs clear immediately; the run restarts in RUN.
- Illegal instruction with HALT_MASK = 4'b0011 -> no halt; with 4'b0100 -> UNKNOWN if a7 != 0x5d.
